// File: rtl/ddr4_rcd_cw_ctrl.sv
// ddr4_rcd_cw_ctrl
// Control-word front end of the RDIMM register model. It snoops the host-side
// DCS/DA/DBA/DBG/DPAR command inputs and does three things:
//   - decodes MRS7 control-word writes into the RC0x (4-bit) and RCnx (8-bit)
//     register files,
//   - checks command/address parity when RC0E[0] is set,
//   - drives ALERT_n with a fixed-width low pulse.
// Ports:
//   CK_t, DRST_n      clock and synchronous active-low reset
//   DCS0_n, DCS1_n    chip selects; either one low marks a command cycle
//   DACT_n, DA, DBA,
//   DBG, DPAR         command/address bus and its even parity bit
//   ALERT_n           parity alert, active low, ALERT_PW cycles wide
//   cw4_words         RC00..RC0F, RC0x at [4x+3:4x]
//   cw8_words         RC1x..RCFx, index n at [8n+7:8n], [7:0] tied to 0
//   cw_wr_stb         one-cycle pulse per accepted write
//   cw_wr_idx         {DA[12],DA[11:8]} of the last accepted write
//   par_err_cnt       saturating parity-error count
//   tmrd_viol         sticky: a write was dropped inside the tMRD window
module ddr4_rcd_cw_ctrl #(
  parameter int ALERT_PW = 60,
  parameter int TMRD_CYC = 8
) (
  input  logic          CK_t,
  input  logic          DRST_n,
  input  logic          DCS0_n,
  input  logic          DCS1_n,
  input  logic          DACT_n,
  input  logic [17:0]   DA,
  input  logic [1:0]    DBA,
  input  logic [1:0]    DBG,
  input  logic          DPAR,
  output logic          ALERT_n,
  output logic [63:0]   cw4_words,
  output logic [127:0]  cw8_words,
  output logic          cw_wr_stb,
  output logic [4:0]    cw_wr_idx,
  output logic [7:0]    par_err_cnt,
  output logic          tmrd_viol
);

  localparam logic [7:0] ALERT_LOAD = 8'(ALERT_PW - 1);
  localparam logic [7:0] TMRD_LOAD  = 8'(TMRD_CYC - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ALERT = 1'b1
  } alert_state_e;

  alert_state_e state, state_nxt;
  logic [7:0]   alert_cnt, alert_cnt_nxt;
  logic [7:0]   hold_cnt;

  logic [3:0]   rc0 [16];
  logic [7:0]   rcx [1:15];

  logic cmd_cyc, par_en, par_odd, par_err;
  logic cw_dec, wr_req, hold_busy, wr_accept, wr_drop;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  assign cmd_cyc   = ~DCS0_n | ~DCS1_n;
  // RC0E[0] as held before this edge; a write that clears it only takes
  // effect from the following cycle.
  assign par_en    = rc0[14][0];
  assign par_odd   = ^{DA, DACT_n, DBA, DBG, DPAR};
  assign par_err   = cmd_cyc & par_en & par_odd;

  assign cw_dec    = cmd_cyc & DACT_n & (DA[16:14] == 3'b000) &
                     (DBA == 2'b11) & DBG[0];
  // 8-bit index 0 is reserved: no write, no strobe, no tMRD bookkeeping.
  assign wr_req    = cw_dec & ~(DA[12] & (DA[11:8] == 4'h0));
  assign hold_busy = (hold_cnt != 8'd0);

  // Parity error outranks the tMRD check, which outranks acceptance.
  assign wr_accept = wr_req & ~par_err & ~hold_busy;
  assign wr_drop   = wr_req & ~par_err &  hold_busy;

  // ---------------------------------------------------------------------------
  // Control-word register files
  // ---------------------------------------------------------------------------
  // NOTE: the register files are reset like any other flop here; downstream
  // configuration decodes them straight out of reset, so X is not acceptable.
  always_ff @(posedge CK_t) begin
    if (!DRST_n) begin
      for (int n = 0; n < 16; n++) rc0[n] <= '0;
      for (int n = 1; n < 16; n++) rcx[n] <= '0;
      cw_wr_idx <= '0;
    end else if (wr_accept) begin
      for (int n = 0; n < 16; n++)
        if (!DA[12] && DA[11:8] == 4'(n)) rc0[n] <= DA[3:0];
      for (int n = 1; n < 16; n++)
        if (DA[12] && DA[11:8] == 4'(n)) rcx[n] <= DA[7:0];
      cw_wr_idx <= DA[12:8];
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cw4_words = '0;
    cw8_words = '0;
    for (int n = 0; n < 16; n++) cw4_words[4*n +: 4] = rc0[n];
    for (int n = 1; n < 16; n++) cw8_words[8*n +: 8] = rcx[n];
  end

  // ---------------------------------------------------------------------------
  // Strobe, tMRD hold counter, violation flag, error counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CK_t) begin
    if (!DRST_n) begin
      cw_wr_stb   <= 1'b0;
      hold_cnt    <= '0;
      tmrd_viol   <= 1'b0;
      par_err_cnt <= '0;
    end else begin
      cw_wr_stb <= wr_accept;

      // Loading TMRD_CYC-1 makes the next write legal exactly TMRD_CYC
      // cycles later; TMRD_CYC=1 loads 0 and allows back-to-back writes.
      if (wr_accept)      hold_cnt <= TMRD_LOAD;
      else if (hold_busy) hold_cnt <= hold_cnt - 8'd1;

      if (wr_drop) tmrd_viol <= 1'b1;

      if (par_err && par_err_cnt != 8'hFF) par_err_cnt <= par_err_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Alert FSM: state register / next state / output
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK_t) begin
    if (!DRST_n) begin
      state     <= IDLE;
      alert_cnt <= '0;
    end else begin
      state     <= state_nxt;
      alert_cnt <= alert_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    alert_cnt_nxt = alert_cnt;
    unique case (state)
      IDLE: begin
        if (par_err) begin
          state_nxt     = ALERT;
          alert_cnt_nxt = ALERT_LOAD;
        end
      end
      ALERT: begin
        // Errors here are counted but never restart the pulse.
        if (alert_cnt == 8'd0) state_nxt     = IDLE;
        else                   alert_cnt_nxt = alert_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ALERT_n = (state != ALERT);
  end

endmodule

// File: tb/tb_ddr4_rcd_cw_ctrl.sv
// tb_ddr4_rcd_cw_ctrl
// Directed bench for ddr4_rcd_cw_ctrl with default parameters
// (ALERT_PW=60, TMRD_CYC=8). A vector table covers plain writes with parity
// checking off; hand-written sequences cover parity alerts, tMRD drops,
// counter saturation and reset during an alert.
module tb_ddr4_rcd_cw_ctrl;

  logic          CK_t = 1'b0;
  logic          DRST_n;
  logic          DCS0_n, DCS1_n, DACT_n, DPAR;
  logic [17:0]   DA;
  logic [1:0]    DBA, DBG;
  logic          ALERT_n;
  logic [63:0]   cw4_words;
  logic [127:0]  cw8_words;
  logic          cw_wr_stb;
  logic [4:0]    cw_wr_idx;
  logic [7:0]    par_err_cnt;
  logic          tmrd_viol;

  int n_checks = 0;
  int n_fail   = 0;

  ddr4_rcd_cw_ctrl #(.ALERT_PW(60), .TMRD_CYC(8)) dut (
    .CK_t(CK_t), .DRST_n(DRST_n), .DCS0_n(DCS0_n), .DCS1_n(DCS1_n),
    .DACT_n(DACT_n), .DA(DA), .DBA(DBA), .DBG(DBG), .DPAR(DPAR),
    .ALERT_n(ALERT_n), .cw4_words(cw4_words), .cw8_words(cw8_words),
    .cw_wr_stb(cw_wr_stb), .cw_wr_idx(cw_wr_idx),
    .par_err_cnt(par_err_cnt), .tmrd_viol(tmrd_viol)
  );

  always #5 CK_t = ~CK_t;

  typedef struct {
    logic       is8;
    logic [3:0] idx;
    logic [7:0] data;
    logic       exp_stb;
    logic [7:0] exp_val;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic idle();
    DCS0_n = 1'b1; DCS1_n = 1'b1; DACT_n = 1'b1;
    DA = '0; DBA = '0; DBG = '0; DPAR = 1'b0;
  endtask

  // bad=1 flips DPAR so the total XOR is odd.
  task automatic send_cmd(input logic act_n, input logic [17:0] da,
                          input logic [1:0] ba, input logic [1:0] bg,
                          input logic bad);
    DCS0_n = 1'b0; DCS1_n = 1'b1;
    DACT_n = act_n; DA = da; DBA = ba; DBG = bg;
    DPAR = (^{da, act_n, ba, bg}) ^ bad;
  endtask

  task automatic send_cw(input logic is8, input logic [3:0] idx,
                         input logic [7:0] data, input logic bad);
    send_cmd(1'b1, {5'b00000, is8, idx, data}, 2'b11, 2'b01, bad);
  endtask

  function automatic logic [7:0] rd(input logic is8, input logic [3:0] idx);
    if (is8) return cw8_words[8*idx +: 8];
    return {4'h0, cw4_words[4*idx +: 4]};
  endfunction

  initial begin
    vecs[0] = '{is8:1'b0, idx:4'h3, data:8'h05, exp_stb:1'b1, exp_val:8'h05};
    vecs[1] = '{is8:1'b1, idx:4'h3, data:8'hA5, exp_stb:1'b1, exp_val:8'hA5};
    vecs[2] = '{is8:1'b1, idx:4'hF, data:8'h3C, exp_stb:1'b1, exp_val:8'h3C};
    vecs[3] = '{is8:1'b0, idx:4'h0, data:8'h0F, exp_stb:1'b1, exp_val:8'h0F};
    vecs[4] = '{is8:1'b1, idx:4'h0, data:8'h77, exp_stb:1'b0, exp_val:8'h00};
    vecs[5] = '{is8:1'b1, idx:4'h1, data:8'h01, exp_stb:1'b1, exp_val:8'h01};
    vecs[6] = '{is8:1'b0, idx:4'hF, data:8'h09, exp_stb:1'b1, exp_val:8'h09};

    // Reset
    idle();
    DRST_n = 1'b0;
    tick(); tick();
    check("rst_alert_n",   ALERT_n,     1);
    check("rst_cw4",       cw4_words,   0);
    check("rst_cw8",       cw8_words,   0);
    check("rst_stb",       cw_wr_stb,   0);
    check("rst_idx",       cw_wr_idx,   0);
    check("rst_par_cnt",   par_err_cnt, 0);
    check("rst_tmrd_viol", tmrd_viol,   0);
    DRST_n = 1'b1;
    tick();

    // Plain writes, parity checking off, spaced beyond tMRD
    for (int i = 0; i < 7; i++) begin
      send_cw(vecs[i].is8, vecs[i].idx, vecs[i].data, 1'b0);
      tick();
      check($sformatf("vec%0d_stb", i), cw_wr_stb, vecs[i].exp_stb);
      check($sformatf("vec%0d_val", i), rd(vecs[i].is8, vecs[i].idx),
            vecs[i].exp_val);
      if (vecs[i].exp_stb)
        check($sformatf("vec%0d_idx", i), cw_wr_idx,
              {vecs[i].is8, vecs[i].idx});
      idle();
      tick();
      check($sformatf("vec%0d_stb_off", i), cw_wr_stb, 0);
      repeat (8) tick();
    end
    check("cw8_low_byte_zero", cw8_words[7:0], 0);
    check("no_viol_after_table", tmrd_viol, 0);

    // E0: enable parity checking (RC0E=1)
    send_cw(1'b0, 4'hE, 8'h01, 1'b0);
    tick();
    check("rc0e_stb",   cw_wr_stb, 1);
    check("rc0e_val",   cw4_words[59:56], 4'h1);
    check("rc0e_idx",   cw_wr_idx, 5'h0E);
    check("rc0e_alert", ALERT_n, 1);

    // E1
    idle();
    tick();
    check("e1_stb_off", cw_wr_stb, 0);
    check("e1_alert",   ALERT_n, 1);

    // E2: bad-parity CW write inside tMRD window
    send_cw(1'b0, 4'h5, 8'h03, 1'b1);
    tick();
    check("badpar_stb",   cw_wr_stb, 0);
    check("badpar_val",   cw4_words[23:20], 0);
    check("badpar_viol",  tmrd_viol, 0);
    check("badpar_cnt",   par_err_cnt, 1);
    check("badpar_alert", ALERT_n, 0);

    // E3: good write 3 cycles after E0 -> dropped
    send_cw(1'b0, 4'h5, 8'h06, 1'b0);
    tick();
    check("tmrd3_stb",  cw_wr_stb, 0);
    check("tmrd3_viol", tmrd_viol, 1);
    check("tmrd3_val",  cw4_words[23:20], 0);

    // E4..E6 idle, E7 still inside window
    idle();
    repeat (3) tick();
    send_cw(1'b0, 4'h5, 8'h06, 1'b0);
    tick();
    check("tmrd7_stb", cw_wr_stb, 0);
    check("tmrd7_val", cw4_words[23:20], 0);

    // E8: exactly TMRD_CYC after E0 -> accepted, even during ALERT
    send_cw(1'b0, 4'h5, 8'h0A, 1'b0);
    tick();
    check("tmrd8_stb",   cw_wr_stb, 1);
    check("tmrd8_val",   cw4_words[23:20], 4'hA);
    check("tmrd8_idx",   cw_wr_idx, 5'h05);
    check("tmrd8_alert", ALERT_n, 0);
    check("tmrd8_viol",  tmrd_viol, 1);

    // E9..E11 idle, E12 second bad (non-CW) command
    idle();
    repeat (3) tick();
    send_cmd(1'b0, 18'h12345, 2'b01, 2'b10, 1'b1);
    tick();
    check("err2_cnt",   par_err_cnt, 2);
    check("err2_stb",   cw_wr_stb, 0);
    check("err2_alert", ALERT_n, 0);

    // E13..E70: pulse started at E2 must end after E61; a good non-CW
    // command at E20 changes nothing.
    for (int e = 13; e <= 70; e++) begin
      if (e == 20) send_cmd(1'b0, 18'h0ABCD, 2'b10, 2'b01, 1'b0);
      else         idle();
      tick();
      check($sformatf("alert_pulse_e%0d", e), ALERT_n, (e <= 61) ? 1'b0 : 1'b1);
    end
    check("noncw_good_cnt", par_err_cnt, 2);
    check("noncw_good_stb", cw_wr_stb, 0);

    // 255 further errors -> saturates at FF
    for (int k = 0; k < 255; k++) begin
      send_cmd(1'b0, 18'h00F0F ^ 18'(k), 2'b00, 2'b11, 1'b1);
      tick();
      if (k == 99) check("sat_mid_cnt", par_err_cnt, 8'd102);
    end
    check("sat_cnt", par_err_cnt, 8'hFF);
    send_cmd(1'b0, 18'h00001, 2'b00, 2'b00, 1'b1);
    tick();
    check("sat_hold_cnt", par_err_cnt, 8'hFF);
    idle();
    repeat (70) tick();
    check("sat_alert_end", ALERT_n, 1);

    // Reset at alert cycle 20
    send_cmd(1'b0, 18'h00002, 2'b00, 2'b00, 1'b1);
    tick();
    idle();
    repeat (19) tick();
    check("pre_rst_alert", ALERT_n, 0);
    DRST_n = 1'b0;
    tick();
    check("mid_rst_alert", ALERT_n, 1);
    check("mid_rst_cw4",   cw4_words, 0);
    check("mid_rst_cw8",   cw8_words, 0);
    check("mid_rst_cnt",   par_err_cnt, 0);
    check("mid_rst_viol",  tmrd_viol, 0);
    check("mid_rst_stb",   cw_wr_stb, 0);
    check("mid_rst_idx",   cw_wr_idx, 0);
    DRST_n = 1'b1;
    tick();
    check("post_rst_alert", ALERT_n, 1);

    // Parity checking is off again after reset
    send_cmd(1'b0, 18'h00003, 2'b00, 2'b00, 1'b1);
    tick();
    check("post_rst_badpar_cnt",   par_err_cnt, 0);
    check("post_rst_badpar_alert", ALERT_n, 1);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr4_rcd_cw_ctrl.md
Name: ddr4_rcd_cw_ctrl

Overview:
Control-word (RCW) front end for the RDIMM register model. It sits on the host side of the RCD command path and snoops the same DCS/DA/DBA/DBG/DPAR inputs. It decodes MRS7 control-word writes into a 4-bit and an 8-bit register file, checks command/address parity, and drives ALERT_n. The stored words feed the RCD's configuration: output inversion, parity enable and the diagnostic counters.

Parameters:
ALERT_PW, 60, ALERT_n low pulse width in CK cycles (legal range 2..255).
TMRD_CYC, 8, minimum CK cycles between accepted control-word writes (legal range 1..255).

Ports:
CK_t  input  1  clock; all state updates on the rising edge.
DRST_n  input  1  synchronous active-low reset.
DCS0_n  input  1  chip select rank 0.
DCS1_n  input  1  chip select rank 1.
DACT_n  input  1  activate.
DA  input  18  address/command.
DBA  input  2  bank address.
DBG  input  2  bank group.
DPAR  input  1  even parity over DA, DACT_n, DBA, DBG.
ALERT_n  output  1  parity-error alert, active low.
cw4_words  output  64  RC00..RC0F, 4 bits each; RC0x sits at [4x+3:4x].
cw8_words  output  128  RC1x..RCFx 8-bit words; index n (1..15) sits at [8n+7:8n]; bits [7:0] are tied to 0.
cw_wr_stb  output  1  one-cycle pulse when a control word is written.
cw_wr_idx  output  5  {DA[12],DA[11:8]} of the last accepted write.
par_err_cnt  output  8  saturating parity-error count.
tmrd_viol  output  1  sticky flag: a write was dropped inside the tMRD window.

Behaviour:
- Reset (DRST_n=0 at an edge) sets:
  - ALERT_n=1, cw4_words=0, cw8_words=0, cw_wr_stb=0, cw_wr_idx=0, par_err_cnt=0, tmrd_viol=0.
  - FSM to IDLE, all counters to 0.
  - Reset asserted mid-alert or mid-hold aborts that activity on the same edge.
- Command cycle: DCS0_n=0 or DCS1_n=0 at the sampling edge.
- CW write decode: command cycle with DACT_n=1, DA[16:14]=3'b000, DBA=2'b11, DBG[0]=1.
  - DA[12]=0: 4-bit write of RC0{DA[11:8]} with data DA[3:0].
  - DA[12]=1: 8-bit write of index DA[11:8] with data DA[7:0]; index 0 is a reserved no-op (no strobe).
- Parity check applies only when RC0E[0]=1, using the value held before the current edge. Error when XOR(DA,DACT_n,DBA,DBG,DPAR)=1 in a command cycle.
- Precedence in a single cycle, highest first:
  1. Parity error: drop the command (no write, no strobe, tmrd_viol unchanged); par_err_cnt+1, saturating at 255.
  2. Write while the hold counter is nonzero: drop it, set tmrd_viol=1.
  3. Otherwise: accept the write.
- Accepted write:
  - The register and cw_wr_idx update on the sampling edge; new value visible one cycle after the command is sampled.
  - cw_wr_stb=1 for exactly that cycle.
  - The hold counter loads TMRD_CYC-1.
- Hold counter:
  - Decrements each cycle while nonzero; the next write is accepted when the counter is 0, i.e. TMRD_CYC cycles after the previous accepted one.
  - TMRD_CYC=1 permits back-to-back writes.
- Alert FSM states: IDLE and ALERT.
  - IDLE -> ALERT on a parity error: ALERT_n=0 from the next cycle, pulse counter loads ALERT_PW-1.
  - ALERT: decrement each cycle; ALERT -> IDLE when the counter is 0, so ALERT_n stays low for exactly ALERT_PW cycles.
  - Errors during ALERT increment par_err_cnt but do not extend or restart the pulse.
  - CW writes with good parity are accepted during ALERT.
- Writing RC0E[0]=0 disables checking from the next cycle; an alert already in progress completes.
- Non-CW commands with good parity have no effect.
- tmrd_viol clears only on reset.

Test Plan:
1. Reset, then CW write DA=18'h00E01 (DA[12]=0, DA[11:8]=E, DA[3:0]=1), DBA=3, DBG=1, DCS0_n=0, good parity -> next cycle cw4_words[59:56]=4'h1, cw_wr_stb=1 for one cycle, cw_wr_idx=5'h0E.
2. With parity enabled, a command with wrong DPAR -> ALERT_n low for exactly 60 cycles starting the following cycle, par_err_cnt=1. A second bad command 10 cycles later -> par_err_cnt=2, ALERT_n still rises at cycle 60.
3. 8-bit write DA[12]=1, DA[11:8]=3, DA[7:0]=8'hA5 -> cw8_words[31:24]=8'hA5. A write with DA[11:8]=0 -> no strobe, no change.
4. Two CW writes 3 cycles apart with TMRD_CYC=8 -> second dropped, tmrd_viol=1. A write at 8 cycles after the first -> accepted.
5. Bad-parity CW write inside the tMRD window -> no write, tmrd_viol unchanged, ALERT pulse. Then 255 further errors -> par_err_cnt holds 8'hFF.
6. DRST_n=0 for one edge at alert cycle 20 -> ALERT_n=1, all words 0, counters 0 on that edge.
